// File: rtl/ff_div.sv
// GF(2^8) divider: q = a * b^254 by square-and-multiply over one shared
// combinational multiplier; fixed 14-cycle latency, 15-cycle throughput.
module ff_div #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       ready,
    output logic       done,
    output logic [7:0] q_out,
    output logic       div_zero
);

    typedef enum logic [1:0] {IDLE, SQR, MUL} state_t;

    state_t     state, state_n;
    logic [7:0] r, s, r_n, s_n, q_n;
    logic [2:0] iter, iter_n;
    logic       dz, dz_n, dzo_n, done_n;
    logic [7:0] mul_a, prod;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ p;
            p = p[7] ? ({p[6:0], 1'b0} ^ POLY) : {p[6:0], 1'b0};
        end
        return acc;
    endfunction

    // SQR squares s; MUL folds s into r. Both share the one multiplier.
    always_comb begin
        mul_a = (state == SQR) ? s : r;
        prod  = gf_mul(mul_a, s);
        ready = (state == IDLE);
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        s_n     = s;
        iter_n  = iter;
        dz_n    = dz;
        q_n     = q_out;
        dzo_n   = div_zero;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    r_n     = a_in;
                    s_n     = b_in;
                    dz_n    = (b_in == 8'h00);
                    iter_n  = 3'd1;
                    state_n = SQR;
                end
            end
            SQR: begin
                s_n     = prod;
                state_n = MUL;
            end
            MUL: begin
                r_n = prod;
                if (iter == 3'd7) begin
                    q_n     = prod;
                    dzo_n   = dz;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    iter_n  = iter + 3'd1;
                    state_n = SQR;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            r        <= '0;
            s        <= '0;
            iter     <= '0;
            dz       <= 1'b0;
            q_out    <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            r        <= r_n;
            s        <= s_n;
            iter     <= iter_n;
            dz       <= dz_n;
            q_out    <= q_n;
            div_zero <= dzo_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_ff_div.sv
// Randomized self-checking bench for ff_div against a brute-force
// inverse-search reference of GF(2^8) division.
module tb_ff_div;

    localparam logic [7:0] POLY = 8'h1B;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       ready;
    logic       done;
    logic [7:0] q_out;
    logic       div_zero;

    int total = 0;
    int bad   = 0;

    ff_div #(.POLY(POLY)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .ready    (ready),
        .done     (done),
        .q_out    (q_out),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Schoolbook polynomial product, then reduce the 15-bit result mod x^8+POLY.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] prodp;
        logic [8:0]  m;
        prodp = '0;
        m     = {1'b1, POLY};
        for (int i = 0; i < 8; i++)
            if (y[i]) prodp = prodp ^ (15'(x) << i);
        for (int i = 14; i >= 8; i--)
            if (prodp[i]) prodp = prodp ^ (15'(m) << (i - 8));
        return prodp[7:0];
    endfunction

    function automatic logic [7:0] ref_div(input logic [7:0] x, input logic [7:0] y);
        if (y == 8'h00) return 8'h00;
        for (int v = 1; v < 256; v++)
            if (ref_mul(y, 8'(v)) == 8'h01) return ref_mul(x, 8'(v));
        return 8'hxx;
    endfunction

    // One request with junk on start/operands while busy; checks latency,
    // busy window, and that results hold with done low afterwards.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic dz);
        int   n;
        int   lowcnt;
        logic seen;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(posedge clk); #1;
        n = 0; seen = 1'b0;
        lowcnt = ready ? 0 : 1;
        while (!seen && n < 30) begin
            @(negedge clk);
            start = 1'($urandom); a_in = 8'($urandom); b_in = 8'($urandom);
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            else if (!ready) lowcnt++;
        end
        check("latency", n, 14);
        check("busy_cycles", lowcnt, 14);
        check("ready_at_done", ready, 1);
        q  = q_out;
        dz = div_zero;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("q_hold", q_out, q);
        check("dz_hold", div_zero, dz);
    endtask

    initial begin
        logic [7:0] q, ea, eb, a, b;
        logic       dz;
        logic [7:0] da [6] = '{8'h01, 8'hC1, 8'h02, 8'h3C, 8'h77, 8'h00};
        logic [7:0] db [6] = '{8'h53, 8'h83, 8'h02, 8'h01, 8'h00, 8'h09};
        logic [7:0] dq [6] = '{8'hCA, 8'h57, 8'h01, 8'h3C, 8'h00, 8'h00};
        logic       dd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        #23;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_q", q_out, 0);
        check("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(da[i], db[i], q, dz);
            check("dir_q", q, dq[i]);
            check("dir_dz", dz, dd[i]);
        end

        for (int i = 0; i < 120; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(a, b, q, dz);
            check("rnd_q", q, ref_div(a, b));
            check("rnd_dz", dz, (b == 8'h00));
        end

        // Captures land every 15th edge while start stays high.
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            start = 1'b1;
            a_in  = 8'($urandom);
            b_in  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            if (k % 15 == 0) begin ea = a_in; eb = b_in; end
            @(posedge clk); #1;
            check("b2b_done", done, (k % 15 == 14));
            check("b2b_ready", ready, (k % 15 == 14));
            if (k % 15 == 14) begin
                check("b2b_q", q_out, ref_div(ea, eb));
                check("b2b_dz", div_zero, (eb == 8'h00));
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);

        @(negedge clk);
        start = 1'b1; a_in = 8'h5A; b_in = 8'h33;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_q", q_out, 0);
        check("abort_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
        end
        run_op(8'hC1, 8'h83, q, dz);
        check("post_abort_q", q, 8'h57);
        check("post_abort_dz", dz, 0);

        for (int v = 1; v < 256; v++) begin
            run_op(8'h01, 8'(v), q, dz);
            check("inv_prod", ref_mul(q, 8'(v)), 8'h01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_div.md
FF_DIV -- requirements
Module: ff_div

Interface
REQ-001 Parameter POLY, default 8'h1B, low 8 bits of the GF(2^8) reduction polynomial (x^8 implied; default = x^8+x^4+x^3+x+1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only when ready=1.
REQ-005 a_in  input  8  dividend.
REQ-006 b_in  input  8  divisor.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 done  output  1  one-cycle pulse; q_out/div_zero valid.
REQ-009 q_out  output  8  quotient a_in * b_in^-1 in GF(2^8).
REQ-010 div_zero  output  1  high with done when the captured b_in was 0.

Function
REQ-011 The block SHALL compute q = a * b^254 (= a/b for b!=0) by square-and-multiply over exponent bits 7..1 of 254, using one shared combinational GF(2^8) multiplier, with no other arithmetic path.
REQ-012 GF multiply SHALL be polynomial product mod (x^8 + POLY), bitwise XOR addition, 8-bit result.
REQ-013 States: IDLE, SQR, MUL; ready=1 only in IDLE.
REQ-014 Capture edge: in IDLE with start=1, latch r<=a_in, s<=b_in, dz<=(b_in==0), iter<=1, go to SQR.
REQ-015 SQR: s<=s*s, go to MUL.
REQ-016 MUL: r<=r*s; if iter==7 go to IDLE and load q_out<=r*s, div_zero<=dz, done<=1; else iter<=iter+1, go to SQR.
REQ-017 Latency fixed: done high in the cycle after the 14th rising edge following the capture edge, for every operand value including b=0 and a=0.
REQ-018 ready SHALL return to 1 in the same cycle done is high; start in that cycle SHALL be accepted (back-to-back, 15-cycle throughput).
REQ-019 start while ready=0 SHALL be ignored; a_in/b_in changes after capture SHALL not affect the result.
REQ-020 b=0: q_out SHALL be 8'h00 and div_zero=1; a=0, b!=0: q_out=8'h00, div_zero=0.
REQ-021 q_out and div_zero SHALL hold their values until the next done; done SHALL be low in every other cycle.
REQ-022 iter SHALL be 3 bits and never exceed 7.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, ready=1, done=0, q_out=8'h00, div_zero=0, r=s=0, iter=0.
REQ-024 Reset asserted mid-operation SHALL abort it; no done SHALL be issued for the aborted request.
REQ-025 First start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-026 a=8'h01, b=8'h53, start one cycle -> done after 14 edges, q_out=8'hCA, div_zero=0, ready low for exactly 14 cycles.
REQ-027 a=8'hC1, b=8'h83 -> q_out=8'h57; a=8'h02, b=8'h02 -> q_out=8'h01; a=8'h3C, b=8'h01 -> q_out=8'h3C.
REQ-028 a=8'h77, b=8'h00 -> done at same latency, q_out=8'h00, div_zero=1; a=8'h00, b=8'h09 -> q_out=8'h00, div_zero=0.
REQ-029 Back-to-back: start held high, operands changed every cycle -> requests captured only at ready=1, one done per 15 cycles, results match captured operands.
REQ-030 Reset asserted 5 cycles after capture -> outputs reset immediately, no done for 20 cycles after release, next request completes correctly.
REQ-031 Exhaustive check: for all b!=0 with a=8'h01, q_out*b SHALL equal 8'h01 under the reference multiply.
